cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 123 ++++++++++++
 tb/tb_cordic_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one CORDIC atan core among N_CH requesters.
// One request in flight at a time; a hung core is abandoned after TIMEOUT wait cycles.
module cordic_sched #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [32*N_CH-1:0]   req_x,
  input  logic [32*N_CH-1:0]   req_y,
  output logic [N_CH-1:0]      req_ready,
  output logic [N_CH-1:0]      rsp_valid,
  output logic [15:0]          rsp_angle,
  output logic                 rsp_err,
  output logic                 cor_start,
  output logic [31:0]          cor_x,
  output logic [31:0]          cor_y,
  output logic                 cor_rst,
  input  logic [15:0]          cor_angle,
  input  logic                 cor_done,
  input  logic                 cor_busy
);

  localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t          state, next;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant_idx;
  logic [N_CH-1:0] grant;
  logic            found;
  logic            accept;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;
  logic            rst_hold;
  logic [31:0]     x_ch [N_CH];
  logic [31:0]     y_ch [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign x_ch[g] = req_x[32*g +: 32];
    assign y_ch[g] = req_y[32*g +: 32];
  end

  // Search starts one past the last accepted channel and wraps around.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      logic [GW-1:0] cidx;
      cidx = GW'((32'(last_grant) + i) % N_CH);
      if (!found && req_valid[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next   = state;
    accept = 1'b0;
    case (state)
      IDLE: begin
        if (found && !cor_busy) begin
          accept = 1'b1;
          next   = ISSUE;
        end
      end
      ISSUE:   next = WAIT;
      WAIT:    if (cor_done || timeout_hit) next = DELIVER;
      DELIVER: next = IDLE;
      default: next = IDLE;
    endcase

    req_ready = accept ? grant : '0;
    cor_start = (state == ISSUE);
    rsp_valid = (state == DELIVER) ? (N_CH'(1) << last_grant) : '0;
    cor_rst   = rst_hold | ((state == DELIVER) && rsp_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GW'(N_CH - 1);
      cor_x      <= '0;
      cor_y      <= '0;
      cnt        <= '0;
      rsp_angle  <= '0;
      rsp_err    <= 1'b0;
      rst_hold   <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
      if (accept) begin
        last_grant <= grant_idx;
        cor_x      <= x_ch[grant_idx];
        cor_y      <= y_ch[grant_idx];
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      // A done arriving in the timeout cycle still wins.
      if (state == WAIT) begin
        if (cor_done) begin
          rsp_angle <= cor_angle;
          rsp_err   <= 1'b0;
        end else if (timeout_hit) begin
          rsp_angle <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched with a behavioural CORDIC core model
// (programmable done latency, return value and hang).
module tb_cordic_sched;
  localparam int N  = 4;
  localparam int TO = 48;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_x, req_y;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [15:0]     rsp_angle;
  logic            rsp_err, cor_start, cor_rst;
  logic [31:0]     cor_x, cor_y;
  logic [15:0]     cor_angle;
  logic            cor_done, cor_busy;

  cordic_sched #(.N_CH(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_angle(rsp_angle), .rsp_err(rsp_err),
    .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y), .cor_rst(cor_rst),
    .cor_angle(cor_angle), .cor_done(cor_done), .cor_busy(cor_busy)
  );

  always #5 clk = ~clk;

  // core model: done is visible exactly lat cycles after the cor_start cycle
  int          lat = 5;
  logic [15:0] ret = 16'h0000;
  bit          hang = 1'b0;
  bit          busy_force = 1'b0;
  bit          stray = 1'b0;
  logic        active = 1'b0;
  logic        mdone = 1'b0;
  int          left = 0;

  assign cor_done  = mdone | stray;
  assign cor_busy  = busy_force | active;
  assign cor_angle = cor_done ? ret : 16'h5A5A;

  always @(posedge clk) begin
    if (cor_rst) begin
      active <= 1'b0;
      mdone  <= 1'b0;
      left   <= 0;
    end else begin
      mdone <= 1'b0;
      if (cor_start) begin
        active <= 1'b1;
        left   <= lat - 1;
      end else if (active && !hang) begin
        left <= left - 1;
        if (left == 1) begin
          mdone  <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          ch;
    logic [15:0] angle;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  int          cyc = 0;
  int          acc_cyc = 0, start_cyc = 0, done_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
  logic [31:0] start_x = '0, start_y = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++)
        if (req_ready[i]) grants.push_back(i);
      if (req_ready != '0) acc_cyc = cyc;
      if (cor_start) begin
        start_cyc = cyc;
        start_x   = cor_x;
        start_y   = cor_y;
        check("start_after_accept", 64'(cyc - acc_cyc), 64'd1);
      end
      if (cor_done) done_cyc = cyc;
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_channel", 64'(rsp_valid), 64'(1 << e.ch));
          check("rsp_angle", 64'(rsp_angle), 64'(e.angle));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_cor_rst", 64'(cor_rst), 64'(e.err));
          if (!e.err) check("rsp_after_done", 64'(cyc - done_cyc), 64'd1);
        end
        rsp_cyc = cyc;
        rsp_cnt++;
      end
    end
  end

  task automatic set_ops(input int ch, input logic [31:0] x, input logic [31:0] y);
    req_x[32*ch +: 32] = x;
    req_y[32*ch +: 32] = y;
  endtask

  task automatic push_exp(input int ch, input logic [15:0] angle, input logic err);
    exp_t e;
    e.ch = ch; e.angle = angle; e.err = err;
    sb.push_back(e);
  endtask

  // Holds each channel in mask valid until it is accepted, then drops it.
  task automatic send(input logic [N-1:0] mask);
    logic [N-1:0] pend, acc;
    pend = mask;
    req_valid = req_valid | mask;
    for (int i = 0; i < 300 && pend != '0; i++) begin
      @(negedge clk);
      acc = req_ready & pend;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      pend = pend & ~acc;
    end
    if (pend != '0) begin
      check("send_timeout", 64'(pend), 64'd0);
      req_valid = req_valid & ~pend;
    end
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 500 && rsp_cnt < target; i++) @(posedge clk);
    #1;
    if (rsp_cnt < target) check("rsp_wait_timeout", 64'(rsp_cnt), 64'(target));
  endtask

  initial begin
    int   g0, drop_cyc, n_before;
    bit   any_ready;

    req_valid = '0; req_x = '0; req_y = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_angle", 64'(rsp_angle), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_cor_start", 64'(cor_start), 64'd0);
    check("rst_cor_x", 64'(cor_x), 64'd0);
    check("rst_cor_y", 64'(cor_y), 64'd0);
    check("rst_cor_rst", 64'(cor_rst), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("cor_rst_hold", 64'(cor_rst), 64'd1);
    @(negedge clk); check("cor_rst_release", 64'(cor_rst), 64'd0);
    @(posedge clk); #1;

    // ch0 basic transaction, latency 5
    lat = 5; ret = 16'h0000;
    set_ops(0, 32'd1000, 32'd0);
    push_exp(0, 16'h0000, 1'b0);
    send(4'b0001);
    wait_rsp(1);
    check("s1_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd7);
    check("s1_start_latency", 64'(start_cyc - acc_cyc), 64'd1);
    check("s1_cor_x", 64'(start_x), 64'd1000);
    check("s1_cor_y", 64'(start_y), 64'd0);

    // ch1 operands pass through, model returns 0xE000
    lat = 4; ret = 16'hE000;
    set_ops(1, 32'h0001_0000, 32'hFFFF_0000);
    push_exp(1, 16'hE000, 1'b0);
    send(4'b0010);
    wait_rsp(2);
    check("s41_cor_x", 64'(start_x), 64'h0001_0000);
    check("s41_cor_y", 64'(start_y), 64'hFFFF_0000);
    check("s41_cor_x_held", 64'(cor_x), 64'h0001_0000);

    // ch2 held off while core busy
    lat = 3; ret = 16'h1111;
    busy_force = 1'b1;
    set_ops(2, 32'd7, 32'd9);
    req_valid[2] = 1'b1;
    any_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready != '0) any_ready = 1'b1;
    end
    check("s39_no_ready_busy", 64'(any_ready), 64'd0);
    @(posedge clk); #1 busy_force = 1'b0;
    drop_cyc = cyc;
    push_exp(2, 16'h1111, 1'b0);
    send(4'b0100);
    check("s39_grant_cycle", 64'(acc_cyc), 64'(drop_cyc));
    wait_rsp(3);

    // ch3 timeout: WAIT occupies start+1..start+48, DELIVER follows
    hang = 1'b1;
    set_ops(3, 32'd5, 32'd6);
    push_exp(3, 16'h0000, 1'b1);
    send(4'b1000);
    wait_rsp(4);
    check("s38_timeout_latency", 64'(rsp_cyc - start_cyc), 64'(TO + 1));
    check("s38_err_hold", 64'(rsp_err), 64'd1);
    check("s38_angle_hold", 64'(rsp_angle), 64'd0);
    check("s38_rsp_valid_one_cycle", 64'(rsp_valid), 64'd0);
    hang = 1'b0;

    // core recovered: normal transaction on ch3
    lat = 3; ret = 16'h0100;
    push_exp(3, 16'h0100, 1'b0);
    send(4'b1000);
    wait_rsp(5);

    // done in the very cycle the timeout is reached counts as success
    lat = TO; ret = 16'h0777;
    push_exp(3, 16'h0777, 1'b0);
    send(4'b1000);
    wait_rsp(6);
    check("done_at_timeout_latency", 64'(rsp_cyc - start_cyc), 64'(TO + 1));

    // all channels request continuously: 0,1,2,3,0
    lat = 3; ret = 16'h2222;
    for (int c = 0; c < N; c++) set_ops(c, 32'(100 + c), 32'(200 + c));
    push_exp(0, 16'h2222, 1'b0);
    push_exp(1, 16'h2222, 1'b0);
    push_exp(2, 16'h2222, 1'b0);
    push_exp(3, 16'h2222, 1'b0);
    push_exp(0, 16'h2222, 1'b0);
    g0 = grants.size();
    req_valid = '1;
    for (int i = 0; i < 400 && grants.size() < g0 + 5; i++) @(posedge clk);
    #1 req_valid = '0;
    check("s37_grant_count", 64'(grants.size() - g0), 64'd5);
    wait_rsp(11);
    for (int k = 0; k < 5; k++)
      if (grants.size() > g0 + k) check("s37_grant_order", 64'(grants[g0 + k]), 64'(k % N));

    // reset during WAIT abandons the request
    hang = 1'b1;
    set_ops(1, 32'd11, 32'd12);
    push_exp(1, 16'h0000, 1'b0);
    n_before = rsp_cnt;
    send(4'b0010);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s40_rsp_valid", 64'(rsp_valid), 64'd0);
    check("s40_req_ready", 64'(req_ready), 64'd0);
    check("s40_cor_start", 64'(cor_start), 64'd0);
    check("s40_cor_x", 64'(cor_x), 64'd0);
    check("s40_cor_y", 64'(cor_y), 64'd0);
    check("s40_rsp_angle", 64'(rsp_angle), 64'd0);
    check("s40_rsp_err", 64'(rsp_err), 64'd0);
    check("s40_cor_rst", 64'(cor_rst), 64'd1);
    sb.delete();
    hang = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s40_no_rsp", 64'(rsp_cnt), 64'(n_before));

    // fresh requests after reset: channel 0 first
    lat = 3; ret = 16'h3333;
    set_ops(0, 32'd21, 32'd22);
    set_ops(1, 32'd23, 32'd24);
    push_exp(0, 16'h3333, 1'b0);
    push_exp(1, 16'h3333, 1'b0);
    g0 = grants.size();
    send(4'b0011);
    wait_rsp(n_before + 2);
    if (grants.size() >= g0 + 2) begin
      check("s40_first_grant", 64'(grants[g0]), 64'd0);
      check("s40_second_grant", 64'(grants[g0 + 1]), 64'd1);
    end else begin
      check("s40_grant_count", 64'(grants.size() - g0), 64'd2);
    end

    // done outside WAIT is ignored
    n_before = rsp_cnt;
    stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stray_done_ignored", 64'(rsp_cnt), 64'(n_before));
    check("stray_done_no_start", 64'(cor_start), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
